dispatch_skid_stage: RTL

//  Parametrised decode->dispatch pipeline stage, successor to the single-register decode latch.

---
 rtl/dispatch_pkg.sv | 35 +++
 rtl/skid_buffer2.sv | 82 ++++++++
 rtl/dispatch_skid_stage.sv | 109 ++++++++++
 3 files changed

// File: rtl/dispatch_pkg.sv
// Shared types for the decode->dispatch stage: micro-op layout, station indices, occupancy states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dispatch_pkg;

    // Reservation station indices in the default four-station machine
    localparam int RS_ALU = 0;
    localparam int RS_BR  = 1;
    localparam int RS_LSU = 2;
    localparam int RS_MUL = 3;

    // Skid buffer occupancy; the head always lives in the main register
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    // Decoded micro-op; the dispatch stage carries it opaquely as UOP_W bits
    typedef struct packed {
        logic [15:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic [3:0]  alu_ctl;
        logic [4:0]  rob_tag1;
        logic [4:0]  rob_tag2;
        logic [1:0]  busy;
        logic [4:0]  rd;
        logic [4:0]  commit_info;
    } uop_t;

    localparam int UOP_W_DEF = $bits(uop_t);

endpackage

// File: rtl/skid_buffer2.sv
// Generic 2-entry FIFO-ordered buffer with registered in_rdy; head held in main_q, overflow in skid_q.
// Latency: push at edge N is visible on out_dat_o/out_vld_o after edge N (one cycle).
// Backpressure: in_rdy_o drops the cycle after the buffer fills; flush empties it and reopens input.
module skid_buffer2
    import dispatch_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_dat_i,
    output logic         out_vld_o,
    output logic [W-1:0] out_dat_o,
    input  logic         pop_i
);

    occ_t         occ_q;
    logic         in_rdy_q;
    logic         out_vld_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         push;

    assign push      = in_vld_i & in_rdy_q;
    assign in_rdy_o  = in_rdy_q;
    assign out_vld_o = out_vld_q;
    assign out_dat_o = main_q;

    // Occupancy FSM with registered ready/valid; payload regs load only on push or shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q     <= EMPTY;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            main_q    <= '0;
            skid_q    <= '0;
        end else if (flush_i) begin
            // Flush wins over push and pop; stale payload is hidden by out_vld_q
            occ_q     <= EMPTY;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            case (occ_q)
                EMPTY: begin
                    if (push) begin
                        main_q    <= in_dat_i;
                        occ_q     <= ONE;
                        out_vld_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop_i) begin
                        main_q <= in_dat_i;
                    end else if (push) begin
                        skid_q   <= in_dat_i;
                        occ_q    <= TWO;
                        in_rdy_q <= 1'b0;
                    end else if (pop_i) begin
                        occ_q     <= EMPTY;
                        out_vld_q <= 1'b0;
                    end
                end
                TWO: begin
                    if (pop_i) begin
                        main_q   <= skid_q;
                        occ_q    <= ONE;
                        in_rdy_q <= 1'b1;
                    end
                end
                default: begin
                    occ_q     <= EMPTY;
                    in_rdy_q  <= 1'b1;
                    out_vld_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dispatch_skid_stage.sv
// Decode->dispatch stage: 2-deep skid buffer, station steering gated by rs_full/rob_full, ROB flush.
// Latency: one cycle push-to-valid; fire is same-cycle combinational from the buffered head.
// Backpressure: registered in_ready; optional STALL_CNT_EN macro adds saturating stall counters.
module dispatch_skid_stage
    import dispatch_pkg::*;
#(
    parameter int UOP_W   = 64,
    parameter int NUM_RS  = 4,
    parameter int RS_BITS = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               globalReset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [UOP_W-1:0]   in_uop,
    input  logic [RS_BITS-1:0] in_station,
    input  logic               in_needs_rs,
    input  logic [NUM_RS-1:0]  rs_full,
    input  logic               rob_full,
    output logic               out_valid,
    output logic [UOP_W-1:0]   out_uop,
    output logic [NUM_RS-1:0]  out_station_req,
    output logic               out_rob_req
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_rob_cnt,
    output logic [CNT_W-1:0]   stall_rs_cnt
`endif
);

    localparam int ENT_W = 1 + RS_BITS + UOP_W;

    logic [ENT_W-1:0]   head_dat;
    logic               head_needs_rs;
    logic [RS_BITS-1:0] head_station;
    logic               rs_blocked;
    logic               fire;

    skid_buffer2 #(
        .W (ENT_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (globalReset_n),
        .flush_i   (flush),
        .in_vld_i  (in_valid),
        .in_rdy_o  (in_ready),
        .in_dat_i  ({in_needs_rs, in_station, in_uop}),
        .out_vld_o (out_valid),
        .out_dat_o (head_dat),
        .pop_i     (fire)
    );

    assign {head_needs_rs, head_station, out_uop} = head_dat;

    // Station full only matters when the head actually needs a station
    assign rs_blocked = head_needs_rs & rs_full[head_station];
    assign fire       = out_valid & ~flush & ~rob_full & ~rs_blocked;

    assign out_rob_req = fire;

    // One-hot steering request, only on the fire cycle and only for station-bound uops
    always_comb begin
        out_station_req = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (fire && head_needs_rs && (head_station == RS_BITS'(i))) begin
                out_station_req[i] = 1'b1;
            end
        end
    end

`ifdef STALL_CNT_EN
    logic             rob_stall;
    logic             rs_stall;
    logic [CNT_W-1:0] stall_rob_cnt_q;
    logic [CNT_W-1:0] stall_rs_cnt_q;

    assign rob_stall = out_valid & rob_full & ~flush;
    assign rs_stall  = out_valid & ~rob_full & rs_blocked & ~flush;

    // Saturating stall counters; flush does not clear them, only reset does
    always_ff @(posedge clk or negedge globalReset_n) begin
        if (!globalReset_n) begin
            stall_rob_cnt_q <= '0;
            stall_rs_cnt_q  <= '0;
        end else begin
            if (rob_stall && (stall_rob_cnt_q != '1)) begin
                stall_rob_cnt_q <= stall_rob_cnt_q + CNT_W'(1);
            end
            if (rs_stall && (stall_rs_cnt_q != '1)) begin
                stall_rs_cnt_q <= stall_rs_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_rob_cnt = stall_rob_cnt_q;
    assign stall_rs_cnt  = stall_rs_cnt_q;
`endif

    // Station select must cover every station, and counters need at least one bit
    a_cfg_ok: assert property (@(posedge clk)
        ((2 ** RS_BITS) >= NUM_RS) && (CNT_W > 0));

    // A station-bound head aimed past the last station could never fire
    a_station_range: assert property (@(posedge clk) disable iff (!globalReset_n)
        (out_valid && head_needs_rs) |-> ({1'b0, head_station} < NUM_RS[RS_BITS:0]));

endmodule
